// File: rtl/md5_pkg.sv
// md5_pkg
// Shared MD5 definitions for the step sequencer and its step datapath:
//   - md5_state_t : sequencer states (IDLE, RUN, FINAL)
//   - T_TABLE     : 64 additive constants, floor(2^32 * |sin(i+1)|)
//   - ROT_TABLE   : 16 rotate amounts indexed by {round, step[1:0]}
//   - word_index  : message word selection for a given step
//   - WORD_W / DIGEST_W : word and digest widths
package md5_pkg;

   localparam int WORD_W   = 32;
   localparam int DIGEST_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FINAL
   } md5_state_t;

   localparam logic [31:0] T_TABLE [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

   localparam logic [4:0] ROT_TABLE [16] = '{
      5'd7, 5'd12, 5'd17, 5'd22,
      5'd5, 5'd9,  5'd14, 5'd20,
      5'd4, 5'd11, 5'd16, 5'd23,
      5'd6, 5'd10, 5'd15, 5'd21
   };

   // The per-round index formulas only depend on i mod 16, so the arithmetic
   // is done in 4 bits and the mod 16 falls out of the truncation.
   function automatic logic [3:0] word_index(input logic [5:0] i);
      logic [3:0] j;
      j = i[3:0];
      case (i[5:4])
         2'd0:    word_index = j;
         2'd1:    word_index = j * 4'd5 + 4'd1;
         2'd2:    word_index = j * 4'd3 + 4'd5;
         default: word_index = j * 4'd7;
      endcase
   endfunction

endpackage

// File: rtl/md5_step.sv
// md5_step
// One combinational MD5 step: new B = B + rotl(A + fn(B,C,D) + X + T, s),
// with the usual register rotation A<=D, C<=B, D<=C.
// Ports:
//   a, b, c, d     in  32  current working state
//   x              in  32  selected message word
//   t              in  32  step constant
//   s              in  5   rotate-left amount
//   round          in  2   selects F / G / H / I
//   a_next..d_next out 32  working state after this step
module md5_step
   import md5_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic [WORD_W-1:0] c,
   input  logic [WORD_W-1:0] d,
   input  logic [WORD_W-1:0] x,
   input  logic [WORD_W-1:0] t,
   input  logic [4:0]        s,
   input  logic [1:0]        round,
   output logic [WORD_W-1:0] a_next,
   output logic [WORD_W-1:0] b_next,
   output logic [WORD_W-1:0] c_next,
   output logic [WORD_W-1:0] d_next
);

   logic [WORD_W-1:0]   fn;
   logic [WORD_W-1:0]   sum;
   logic [2*WORD_W-1:0] rot_wide;

   // Boolean function for the round, then the four-way mod 2^32 sum and the
   // rotate. The rotate shifts a doubled copy of the sum left so the bits
   // falling off the top reappear at the bottom of the upper half.
   always_comb begin
      case (round)
         2'd0:    fn = (b & c) | (~b & d);
         2'd1:    fn = (b & d) | (c & ~d);
         2'd2:    fn = b ^ c ^ d;
         default: fn = c ^ (b | ~d);
      endcase
      sum      = a + fn + x + t;
      rot_wide = {sum, sum} << s;
      b_next   = b + rot_wide[2*WORD_W-1:WORD_W];
   end

   assign a_next = d;
   assign c_next = b;
   assign d_next = c;

endmodule

// File: rtl/md5_step_sequencer.sv
// md5_step_sequencer
// Runs one 512-bit MD5 block compression as 64 single-cycle steps through a
// shared md5_step datapath, then publishes the digest with a one-cycle done.
// Ports:
//   clk        in  1    rising-edge clock
//   rst_n      in  1    asynchronous active-low reset
//   start      in  1    begin compression (sampled only in IDLE)
//   abort      in  1    synchronous abort back to IDLE, no done
//   msg_block  in  512  X[k] = msg_block[32k+31:32k]
//   chain_in   in  128  {D,C,B,A} initial chaining value
//   busy       out 1    high while RUN or FINAL
//   done       out 1    one-cycle pulse when digest updates
//   digest     out 128  {D,C,B,A} result, held until the next done
// Build option: define MD5_CHAIN_ADD_EN to add the latched chaining value to
// the final state (full compression); otherwise the raw final A..D is output.
module md5_step_sequencer
   import md5_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [511:0]        msg_block,
   input  logic [DIGEST_W-1:0] chain_in,
   output logic                busy,
   output logic                done,
   output logic [DIGEST_W-1:0] digest
);

   md5_state_t          state;
   logic [5:0]          step;
   logic [WORD_W-1:0]   a, b, c, d;
   logic [511:0]        msg_q;
   logic [WORD_W-1:0]   a_nx, b_nx, c_nx, d_nx;
   logic [3:0]          k_idx;
   logic [WORD_W-1:0]   x_word;
   logic [DIGEST_W-1:0] final_digest;

`ifdef MD5_CHAIN_ADD_EN
   logic [DIGEST_W-1:0] chain_q;
`endif

   // Per-step selection of message word, constant and rotate amount, all
   // driven straight from the step counter.
   always_comb begin
      k_idx  = word_index(step);
      x_word = msg_q[{k_idx, 5'd0} +: WORD_W];
   end

   md5_step u_step (
      .a      (a),
      .b      (b),
      .c      (c),
      .d      (d),
      .x      (x_word),
      .t      (T_TABLE[step]),
      .s      (ROT_TABLE[{step[5:4], step[1:0]}]),
      .round  (step[5:4]),
      .a_next (a_nx),
      .b_next (b_nx),
      .c_next (c_nx),
      .d_next (d_nx)
   );

   // Value published in FINAL; the chaining add is optional because some
   // systems do it downstream of this block.
`ifdef MD5_CHAIN_ADD_EN
   always_comb begin
      final_digest = {chain_q[127:96] + d, chain_q[95:64] + c,
                      chain_q[63:32]  + b, chain_q[31:0]  + a};
   end
`else
   always_comb begin
      final_digest = {d, c, b, a};
   end
`endif

   // Main sequencer. done defaults low every cycle so it can only ever be a
   // single-cycle pulse out of FINAL. abort wins over start even in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         step   <= 6'd0;
         a      <= '0;
         b      <= '0;
         c      <= '0;
         d      <= '0;
         msg_q  <= '0;
`ifdef MD5_CHAIN_ADD_EN
         chain_q <= '0;
`endif
         busy   <= 1'b0;
         done   <= 1'b0;
         digest <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  msg_q <= msg_block;
`ifdef MD5_CHAIN_ADD_EN
                  chain_q <= chain_in;
`endif
                  a     <= chain_in[31:0];
                  b     <= chain_in[63:32];
                  c     <= chain_in[95:64];
                  d     <= chain_in[127:96];
                  step  <= 6'd0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  a    <= a_nx;
                  b    <= b_nx;
                  c    <= c_nx;
                  d    <= d_nx;
                  step <= step + 6'd1;
                  if (step == 6'd63) begin
                     state <= ST_FINAL;
                  end
               end
            end
            ST_FINAL: begin
               if (!abort) begin
                  digest <= final_digest;
                  done   <= 1'b1;
               end
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md5_step_sequencer.sv
// tb_md5_step_sequencer
// Directed bench for md5_step_sequencer using the empty-string and "abc"
// single-block vectors. Expected digests and done cycles are queued when a
// block is started and popped when done is observed.
// Works with or without MD5_CHAIN_ADD_EN defined.
module tb_md5_step_sequencer;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         abort;
   logic [511:0] msg_block;
   logic [127:0] chain_in;
   logic         busy;
   logic         done;
   logic [127:0] digest;

   typedef struct {
      logic [127:0] dg;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   cycle;
   int   checks;
   int   passed;

   localparam logic [127:0] IV        = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
   localparam logic [127:0] FULL_EMPTY = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
   localparam logic [127:0] FULL_ABC   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};

   logic [511:0] msg_empty;
   logic [511:0] msg_abc;

   md5_step_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .msg_block (msg_block),
      .chain_in  (chain_in),
      .busy      (busy),
      .done      (done),
      .digest    (digest)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Free-running edge counter used to time done against its start edge
   always @(posedge clk) begin
      cycle <= cycle + 1;
   end

   // Without the chaining add, the block outputs the full digest minus IV
   function automatic logic [127:0] expDigest(input logic [127:0] full, input logic [127:0] iv);
      logic [127:0] r;
`ifdef MD5_CHAIN_ADD_EN
      r = full;
      r = r | (iv & 128'd0);
`else
      for (int w = 0; w < 4; w++) begin
         r[32*w +: 32] = full[32*w +: 32] - iv[32*w +: 32];
      end
`endif
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   // Called on a negedge: drives start for one edge, then scrambles the inputs
   // so that any late sampling of msg_block/chain_in shows up as a bad digest.
   task automatic applyStimulus(input logic [511:0] msg, input logic [127:0] iv, input logic [127:0] full);
      exp_t e;
      start     = 1'b1;
      msg_block = msg;
      chain_in  = iv;
      @(negedge clk);
      start     = 1'b0;
      msg_block = {16{32'hdeadbeef}};
      chain_in  = {4{32'h5a5a5a5a}};
      e.dg  = expDigest(full, iv);
      e.cyc = cycle + 65;
      sb.push_back(e);
      checkOutput("busy_after_start", busy, 1'b1);
   endtask

   task automatic waitDone(input string tag, input int budget);
      bit   seen;
      exp_t e;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      checkOutput({tag, "_done_seen"}, seen, 1'b1);
      if (seen) begin
         checkOutput({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_digest"}, digest, e.dg);
            checkOutput({tag, "_done_cycle"}, cycle, e.cyc);
            checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
         end
      end
   endtask

   task automatic watchNoDone(input string tag, input int budget);
      int hits;
      hits = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done !== 1'b0) hits++;
      end
      checkOutput({tag, "_no_done"}, hits, 0);
   endtask

   initial begin
      int done_cyc1;
      checks    = 0;
      passed    = 0;
      cycle     = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      msg_block = '0;
      chain_in  = '0;
      msg_empty = '0;
      msg_empty[31:0] = 32'h00000080;
      msg_abc   = '0;
      msg_abc[31:0]    = 32'h80636261;
      msg_abc[479:448] = 32'h00000018;

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_done", done, 1'b0);
      checkOutput("reset_digest", digest, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Empty string, with an ignored start pulse at step 10
      $display("[TB] empty string block");
      applyStimulus(msg_empty, IV, FULL_EMPTY);
      repeat (10) @(negedge clk);
      start     = 1'b1;
      msg_block = msg_abc;
      @(negedge clk);
      start     = 1'b0;
      waitDone("empty", 100);
      done_cyc1 = cycle;

      // Back-to-back "abc" started in the done cycle
      $display("[TB] back-to-back abc block");
      applyStimulus(msg_abc, IV, FULL_ABC);
      waitDone("abc_b2b", 100);
      checkOutput("b2b_spacing", cycle - done_cyc1, 66);
      @(negedge clk);
      checkOutput("done_pulse_width", done, 1'b0);

      // Abort at step 30: no done, digest keeps the "abc" result
      $display("[TB] abort during step 30");
      applyStimulus(msg_empty, IV, FULL_EMPTY);
      void'(sb.pop_back());
      repeat (29) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_busy", busy, 1'b0);
      watchNoDone("abort", 80);
      checkOutput("abort_digest_hold", digest, expDigest(FULL_ABC, IV));

      // Run after abort completes normally
      applyStimulus(msg_empty, IV, FULL_EMPTY);
      waitDone("after_abort", 100);
      @(negedge clk);

      // Reset at step 40 clears outputs immediately and suppresses done
      $display("[TB] reset during step 40");
      applyStimulus(msg_abc, IV, FULL_ABC);
      void'(sb.pop_back());
      repeat (39) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", busy, 1'b0);
      checkOutput("midreset_done", done, 1'b0);
      checkOutput("midreset_digest", digest, '0);
      @(negedge clk);
      rst_n = 1'b1;
      watchNoDone("midreset", 80);

      // Run after reset completes normally
      applyStimulus(msg_abc, IV, FULL_ABC);
      waitDone("after_reset", 100);
      @(negedge clk);
      checkOutput("final_idle_busy", busy, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
